pipe_hazard_ctrl: RTL

- Pipeline sequencing controller around the EX-stage ALU.
- Consumes the ALU branch outcome (branch_true, new_addr) and the ID/EX/MEM register indices.
- Produces PC redirect, IF/ID and ID/EX flushes, load-use stalls, and operand-forwarding selects for the ALU src1/src2 muxes.
- Keeps saturating performance counters for taken branches and stall cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    // ALU operand mux selects
    typedef enum logic [1:0] {
        FwdReg   = 2'b00,
        FwdExMem = 2'b01,
        FwdMemWb = 2'b10
    } fwd_sel_e;

    // Sequencing FSM states
    typedef enum logic {
        HzRun   = 1'b0,
        HzFlush = 1'b1
    } hz_state_e;

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_pick(input logic exmem_hit, input logic memwb_hit);
        logic [1:0] sel;
        sel = FwdReg;
        if (exmem_hit) begin
            sel = FwdExMem;
        end else if (memwb_hit) begin
            sel = FwdMemWb;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
module pipe_hazard_ctrl_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] One = W'(1);

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + One;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Branch redirect / flush, load-use stall and forwarding control around the EX stage.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned REG_IDX_W    = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] ex_rs1,
    input  logic [REG_IDX_W-1:0] ex_rs2,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_branch_true,
    input  logic [ADDR_W-1:0]    ex_new_addr,
    input  logic                 mem_wr,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 wb_wr,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic                 stall_pc,
    output logic                 stall_ifid,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 redirect_valid,
    output logic [ADDR_W-1:0]    redirect_addr,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic [CNT_W-1:0]     branch_cnt,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES - 1);

    hz_state_e  state_q;
    logic [2:0] fcnt_q;
    logic       in_run;
    logic       take;
    logic       hz_raw;
    logic       hz;

    // Branch outcome and load-use only matter while EX holds a live instruction.
    always_comb begin
        in_run = (state_q == HzRun);
        take   = in_run & ex_valid & ex_branch_true;
        hz_raw = ex_valid & ex_is_load & (ex_rd != '0) &
                 ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
        // A taken branch squashes the dependent ID instruction anyway.
        hz     = in_run & hz_raw & ~take;
    end

    // Stall/flush and forwarding selects.
    always_comb begin
        stall_pc   = hz;
        stall_ifid = hz;
        flush_ifid = ~in_run;
        flush_idex = ~in_run | hz;
        fwd_a_sel  = fwd_pick(mem_wr & (mem_rd != '0) & (mem_rd == ex_rs1),
                              wb_wr & (wb_rd != '0) & (wb_rd == ex_rs1));
        fwd_b_sel  = fwd_pick(mem_wr & (mem_rd != '0) & (mem_rd == ex_rs2),
                              wb_wr & (wb_rd != '0) & (wb_rd == ex_rs2));
    end

    // Sequencing FSM with registered one-shot redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HzRun;
            fcnt_q         <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else begin
            redirect_valid <= 1'b0;
            unique case (state_q)
                HzRun: begin
                    if (take) begin
                        state_q        <= HzFlush;
                        fcnt_q         <= FcntInit;
                        redirect_valid <= 1'b1;
                        redirect_addr  <= ex_new_addr;
                    end
                end
                HzFlush: begin
                    if (fcnt_q == 3'd0) begin
                        state_q <= HzRun;
                    end else begin
                        fcnt_q <= fcnt_q - 3'd1;
                    end
                end
            endcase
        end
    end

    pipe_hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (take),
        .count (branch_cnt)
    );

    pipe_hazard_ctrl_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hz),
        .count (stall_cnt)
    );

endmodule
